// File: rtl/draw_scheduler_if.sv
// Requester, drawunit and frame-bank signals of the draw scheduler.
// The scheduler uses the slave modport; the requester/drawunit side uses master.
interface draw_scheduler_if #(
    parameter int DATA_W = 256
);
    logic [1:0][7:0]        req_cmd;
    logic [1:0][DATA_W-1:0] req_data;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [7:0]             du_command;
    logic [DATA_W-1:0]      du_data;
    logic                   du_commit;
    logic                   du_ack;
    logic                   du_done;
    logic [1:0]             du_bank;
    logic [1:0]             display_bank;
    logic                   vsync;
    logic                   busy;
    logic [15:0]            done_count;

    modport slave (
        input  req_cmd, req_data, req_valid, du_ack, du_done, vsync,
        output req_ready, du_command, du_data, du_commit, du_bank, display_bank,
               busy, done_count
    );

    modport master (
        output req_cmd, req_data, req_valid, du_ack, du_done, vsync,
        input  req_ready, du_command, du_data, du_commit, du_bank, display_bank,
               busy, done_count
    );
endinterface

// File: rtl/draw_scheduler.sv
// Two-port round-robin command scheduler for drawunit, with one holding register
// per port and vsync-synchronised frame-bank rotation on swap commands.
module draw_scheduler #(
    parameter int         DATA_W    = 256,
    parameter logic [7:0] CMD_SWAP  = 8'hFF,
    parameter int         NUM_BANKS = 2
) (
    input logic             clk,
    input logic             rst_n,
    draw_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ISSUE      = 2'd1;
    localparam logic [1:0] WAIT_DONE  = 2'd2;
    localparam logic [1:0] WAIT_VSYNC = 2'd3;
    localparam logic [1:0] LAST_BANK  = 2'(NUM_BANKS - 1);

    logic [1:0]             state;
    logic [1:0]             full_q;
    logic [1:0][7:0]        cmd_q;
    logic [1:0][DATA_W-1:0] data_q;
    logic                   last_grant;
    logic                   gnt_q;
    logic                   gnt;
    logic                   retire;
    logic [1:0]             clr;
    logic [7:0]             du_command;
    logic [DATA_W-1:0]      du_data;
    logic                   du_commit;
    logic [1:0]             du_bank;
    logic [1:0]             display_bank;
    logic [15:0]            done_count;

    // Contention goes to the port that did not win last; otherwise the full one.
    assign gnt    = (&full_q) ? ~last_grant : full_q[1];
    assign retire = (state == ISSUE && bus.du_ack) || (state == WAIT_VSYNC && bus.vsync);

    always_comb begin
        clr = 2'b00;
        for (int p = 0; p < 2; p++) clr[p] = retire && (gnt_q == 1'(p));
    end

    // A slot refills only once it reads empty, so clear and capture never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            cmd_q  <= '0;
            data_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (clr[p]) begin
                    full_q[p] <= 1'b0;
                end else if (bus.req_valid[p] && !full_q[p]) begin
                    full_q[p] <= 1'b1;
                    cmd_q[p]  <= bus.req_cmd[p];
                    data_q[p] <= bus.req_data[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            gnt_q        <= 1'b0;
            du_command   <= '0;
            du_data      <= '0;
            du_commit    <= 1'b0;
            du_bank      <= '0;
            display_bank <= LAST_BANK;
            done_count   <= '0;
        end else begin
            case (state)
                IDLE: if (|full_q) begin
                    last_grant <= gnt;
                    gnt_q      <= gnt;
                    if (cmd_q[gnt] == CMD_SWAP) begin
                        state <= WAIT_VSYNC;
                    end else begin
                        du_command <= cmd_q[gnt];
                        du_data    <= data_q[gnt];
                        du_commit  <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: if (bus.du_ack) begin
                    du_commit <= 1'b0;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: if (bus.du_done) begin
                    done_count <= done_count + 16'd1;
                    state      <= IDLE;
                end
                WAIT_VSYNC: if (bus.vsync) begin
                    display_bank <= du_bank;
                    du_bank      <= (du_bank == LAST_BANK) ? 2'd0 : du_bank + 2'd1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = ~full_q;
    assign bus.busy         = (state != IDLE) || (|full_q);
    assign bus.du_command   = du_command;
    assign bus.du_data      = du_data;
    assign bus.du_commit    = du_commit;
    assign bus.du_bank      = du_bank;
    assign bus.display_bank = display_bank;
    assign bus.done_count   = done_count;
endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: a scoreboard queue holds the expected issue
// order, a monitor pops it on every drawunit transfer, a responder answers du_done.
module tb_draw_scheduler;
    localparam int DATA_W = 256;

    typedef struct {
        logic [7:0]        cmd;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   xfers = 0;
    int   man_req = 0;
    bit   auto_done = 1'b1;
    exp_t q[$];

    draw_scheduler_if #(.DATA_W(DATA_W)) bus ();

    draw_scheduler #(.DATA_W(DATA_W), .CMD_SWAP(8'hFF), .NUM_BANKS(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] c, input logic [DATA_W-1:0] d);
        exp_t e;
        e.cmd  = c;
        e.data = d;
        return e;
    endfunction

    // Monitor: a transfer is commit & ack seen before the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.du_commit && bus.du_ack) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got cmd %0h expected none", bus.du_command);
                end else begin
                    e = q.pop_front();
                    chk("issue_cmd", bus.du_command, e.cmd);
                    chk("issue_data", bus.du_data, e.data);
                    xfers++;
                end
            end
        end
    end

    // Responder: du_done pulse about four cycles after each transfer.
    initial begin
        int dcnt = 0;
        int man_seen = 0;
        bus.du_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.du_done = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) bus.du_done = auto_done;
            end
            if (man_req != man_seen) begin
                bus.du_done = 1'b1;
                man_seen = man_req;
            end
            if (rst_n && bus.du_commit && bus.du_ack) dcnt = 4;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.vsync = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, bus.busy, 0);
    endtask

    // Offer a command on port p at a falling edge for exactly one rising edge.
    task automatic send(input int p, input logic [7:0] c, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.req_cmd[p]   = c;
        bus.req_data[p]  = d;
        bus.req_valid[p] = 1'b1;
        @(posedge clk);
        #1 bus.req_valid[p] = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(negedge clk);
        bus.vsync = 1'b1;
        @(negedge clk);
        bus.vsync = 1'b0;
    endtask

    initial begin
        int commit_cyc, ready_low, n, caps0, caps1, x0;
        logic [1:0] exp_du[3];
        logic [1:0] exp_disp[3];
        exp_du   = '{2'd1, 2'd2, 2'd0};
        exp_disp = '{2'd0, 2'd1, 2'd2};
        bus.req_cmd   = '0;
        bus.req_data  = '0;
        bus.req_valid = 2'b00;
        bus.du_ack    = 1'b1;
        bus.vsync     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 2'b11);
        chk("rst_commit", bus.du_commit, 0);
        chk("rst_command", bus.du_command, 0);
        chk("rst_data", bus.du_data, 0);
        chk("rst_du_bank", bus.du_bank, 0);
        chk("rst_display_bank", bus.display_bank, 2);
        chk("rst_done_count", bus.done_count, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;

        // Single command, ack tied high.
        q.push_back(mk(8'h01, '1));
        send(0, 8'h01, '1);
        commit_cyc = 0;
        ready_low  = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.du_commit) commit_cyc++;
            if (!bus.req_ready[0]) ready_low++;
        end
        chk("single_commit_cycles", commit_cyc, 1);
        chk("single_ready_low", ready_low, 2);
        chk("single_done_count", bus.done_count, 1);
        wait_idle("single");

        // Same-cycle contention after reset: port 0 first.
        do_reset();
        q.push_back(mk(8'h01, {32{8'h11}}));
        q.push_back(mk(8'h02, {32{8'h22}}));
        @(negedge clk);
        bus.req_cmd[0] = 8'h01; bus.req_data[0] = {32{8'h11}};
        bus.req_cmd[1] = 8'h02; bus.req_data[1] = {32{8'h22}};
        bus.req_valid = 2'b11;
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        wait_idle("contend");
        chk("contend_done_count", bus.done_count, 2);
        chk("contend_queue", q.size(), 0);

        // Contention with port 0 refilled immediately: 01, 02, 01.
        do_reset();
        q.push_back(mk(8'h01, {32{8'h11}}));
        q.push_back(mk(8'h02, {32{8'h22}}));
        q.push_back(mk(8'h01, {32{8'h11}}));
        @(negedge clk);
        bus.req_valid = 2'b11;
        caps0 = 0;
        caps1 = 0;
        n = 0;
        while (bus.req_valid != 2'b00 && n < 100) begin
            if (bus.req_valid[0] && bus.req_ready[0]) caps0++;
            if (bus.req_valid[1] && bus.req_ready[1]) caps1++;
            @(posedge clk);
            #1;
            if (caps0 == 2) bus.req_valid[0] = 1'b0;
            if (caps1 == 1) bus.req_valid[1] = 1'b0;
            @(negedge clk);
            n++;
        end
        wait_idle("rr");
        chk("rr_queue", q.size(), 0);
        chk("rr_done_count", bus.done_count, 3);

        // Ack withheld for 10 cycles: command held stable, one transfer.
        do_reset();
        @(posedge clk);
        #1 bus.du_ack = 1'b0;
        x0 = xfers;
        q.push_back(mk(8'h03, {8{32'hDEADBEEF}}));
        send(0, 8'h03, {8{32'hDEADBEEF}});
        n = 0;
        while (!bus.du_commit && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (10) begin
            chk("hold_commit", bus.du_commit, 1);
            chk("hold_command", bus.du_command, 8'h03);
            chk("hold_data", bus.du_data, {8{32'hDEADBEEF}});
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.du_ack = 1'b1;
        wait_idle("hold");
        chk("hold_xfers", xfers - x0, 1);

        // Bank swaps from port 1 with three banks; vsync in IDLE is ignored.
        do_reset();
        pulse_vsync();
        chk("idle_vsync_du_bank", bus.du_bank, 0);
        chk("idle_vsync_display", bus.display_bank, 2);
        for (int i = 0; i < 3; i++) begin
            send(1, 8'hFF, '0);
            repeat (4) @(negedge clk);
            chk("swap_wait_busy", bus.busy, 1);
            chk("swap_wait_ready1", bus.req_ready[1], 0);
            chk("swap_wait_commit", bus.du_commit, 0);
            chk("swap_wait_du_bank", bus.du_bank, exp_du[(i + 2) % 3]);
            pulse_vsync();
            chk("swap_du_bank", bus.du_bank, exp_du[i]);
            chk("swap_display_bank", bus.display_bank, exp_disp[i]);
            wait_idle("swap");
        end
        chk("swap_done_count", bus.done_count, 0);

        // Reset while in WAIT_DONE with both slots full.
        do_reset();
        auto_done = 1'b0;
        q.push_back(mk(8'h01, {32{8'h11}}));
        @(negedge clk);
        bus.req_cmd[0] = 8'h01; bus.req_data[0] = {32{8'h11}};
        bus.req_cmd[1] = 8'h02; bus.req_data[1] = {32{8'h22}};
        bus.req_valid = 2'b11;
        @(posedge clk);
        #1;
        bus.req_cmd[0] = 8'h05;
        bus.req_valid[1] = 1'b0;
        repeat (6) @(negedge clk);
        chk("late_both_full", bus.req_ready, 2'b00);
        chk("late_command", bus.du_command, 8'h01);
        #2 rst_n = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        chk("arst_req_ready", bus.req_ready, 2'b11);
        chk("arst_commit", bus.du_commit, 0);
        chk("arst_command", bus.du_command, 0);
        chk("arst_data", bus.du_data, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_display_bank", bus.display_bank, 2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        man_req++;
        repeat (3) @(negedge clk);
        chk("late_done_count", bus.done_count, 0);
        chk("late_busy", bus.busy, 0);
        chk("final_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule
